// File: rtl/pipe_haz_pkg.sv
// rtl/pipe_haz_pkg.sv - shared types and helpers for the hazard/forwarding scoreboard
package pipe_haz_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int FWD_RF     = 0;

  // rd is sized for the default 32-register file
  typedef struct packed {
    logic                  v;
    logic [REG_AW_DEF-1:0] rd;
    logic                  ld;
  } haz_entry_t;

  function automatic logic is_zero_reg(input logic [REG_AW_DEF-1:0] r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/haz_match.sv
// rtl/haz_match.sv - youngest-first search of the in-flight writers for one source operand
module haz_match
  import pipe_haz_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FWD_W = 2
) (
  input  haz_entry_t [DEPTH-1:0] stages,
  input  logic                   src_valid,
  input  logic [REG_AW_DEF-1:0]  src_addr,
  output logic                   hit,
  output logic [FWD_W-1:0]       k,
  output logic                   is_load
);

  // Scan oldest to youngest so the youngest matching stage is written last
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    is_load = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (src_valid && !is_zero_reg(src_addr) && stages[j].v && stages[j].rd == src_addr) begin
        hit     = 1'b1;
        k       = FWD_W'(j + 1);
        is_load = stages[j].ld;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - stage shift pipe, forwarding selects and load-use stall; HAZ_STATS_EN adds counters
module pipe_hazard_scoreboard
  import pipe_haz_pkg::*;
#(
  parameter  int NREGS      = 32,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int NSRC       = 2,
  localparam int REG_AW     = $clog2(NREGS),
  localparam int FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic                   issue_load,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*FWD_W-1:0]  fwd_sel
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            fwd_cnt
`endif
);

  haz_entry_t [DEPTH-1:0] stage_q, stage_d;
  logic [NSRC-1:0]        hazard;
  logic [NSRC*FWD_W-1:0]  sel_raw;
  logic                   accept;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic             hit;
    logic             ld;
    logic [FWD_W-1:0] k;

    haz_match #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_match (
      .stages   (stage_q),
      .src_valid(src_valid[i]),
      .src_addr (REG_AW_DEF'(src_addr[i*REG_AW +: REG_AW])),
      .hit      (hit),
      .k        (k),
      .is_load  (ld)
    );

    // A load not yet past LOAD_STAGE cannot be forwarded; the select falls back to the RF
    assign hazard[i] = hit && ld && (k < FWD_W'(LOAD_STAGE));
    assign sel_raw[i*FWD_W +: FWD_W] = (hit && !hazard[i]) ? k : FWD_W'(FWD_RF);
  end

  assign stall   = reset && issue_valid && !flush && (|hazard);
  assign fwd_sel = reset ? sel_raw : '0;
  assign accept  = issue_valid && issue_we && !is_zero_reg(REG_AW_DEF'(issue_rd)) && !stall && !flush;

  always_comb begin
    stage_d = '0;
    for (int j = 1; j < DEPTH; j++) begin
      stage_d[j] = stage_q[j-1];
    end
    if (accept) begin
      stage_d[0].v  = 1'b1;
      stage_d[0].rd = REG_AW_DEF'(issue_rd);
      stage_d[0].ld = issue_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stage_q <= '0;
    else        stage_q <= stage_d;
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if ((|fwd_sel) && fwd_cnt_q != 32'hFFFF_FFFF) fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
